scan_sequencer: RTL and testbench
=================================

# scan_sequencer

Parametrised channel-scan controller for the spectrogram extractor. On a frame trigger (`ovf`), it steps a channel select through every enabled filter channel. Each channel is held for a fixed slot of `SLOT_LEN` clocks, and a shift/load strobe is issued at the start of each slot. After the last channel it emits a one-cycle clear pulse. Compared with the fixed 16-channel sequencer, it adds a per-frame channel-enable mask, a one-deep trigger queue, a missed-trigger counter and an abort.

## Interface
Parameters:
- `N_CH`, default 16: number of channels, range 2..16. Channel 0 is the RTC slot.
- `SLOT_LEN`, default 12: clocks per channel slot, range 2..256.
- `SEL_W`, default `$clog2(N_CH)`: width of the select output.
- `CNT_W`, default `$clog2(SLOT_LEN)`: width of the slot counter.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset_n`  in  1: synchronous active-low reset.
- `ovf`  in  1: frame trigger, level-sampled each cycle.
- `ch_en`  in  N_CH: channel-enable mask, captured at scan start.
- `abort`  in  1: terminates the current scan.
- `selection`  out  SEL_W: current channel index.
- `SL_out`  out  1: load strobe, high on cycle 0 of every slot.
- `rst`  out  1: end-of-scan clear pulse, one cycle.
- `counter_register`  out  CNT_W: position within the current slot.
- `busy`  out  1: high in SCAN and CLEAR.
- `missed`  out  8: count of dropped triggers, saturates at 255.

## Operation
State machine:
- States: IDLE, SCAN, CLEAR.
- IDLE → SCAN when `ovf`=1 and the mask has at least one enabled bit.
  - `ch_en` is latched into `mask_q`.
  - `selection` loads the lowest enabled index.
  - `counter_register` is 0.
- IDLE → CLEAR when `ovf`=1 and `ch_en`=0. This is an empty frame, and `rst` still pulses.
- SCAN:
  - `counter_register` increments by 1 each cycle.
  - At `SLOT_LEN-1` it wraps to 0 and `selection` advances to the next higher enabled index in `mask_q`.
  - Disabled channels take zero cycles.
  - If no higher enabled index exists, the next state is CLEAR.
- SCAN → CLEAR when `abort`=1, regardless of counter value. This also clears any pending trigger.
- CLEAR lasts exactly one cycle with `rst`=1.
  - Next state is SCAN if a trigger is pending; the mask is re-captured from `ch_en` at that moment. If the re-captured mask is zero, go to CLEAR again.
  - Otherwise the next state is IDLE.

Trigger queue:
- `ovf`=1 while `busy` and nothing is pending sets `pending`.
- `ovf`=1 while `pending` is already set increments `missed`, saturating at 255.
- `ovf` in the same cycle that CLEAR exits is treated as busy: it sets `pending` if empty, otherwise it counts as missed.

Outputs:
- `SL_out` = (state==SCAN) && (`counter_register`==0). It is Moore-decoded from registers.
- `rst` = (state==CLEAR). `busy` = (state!=IDLE).
- `selection` is 0 in IDLE and CLEAR. In SCAN it holds the active index.
- `abort` in IDLE or CLEAR is ignored.

Reset (`reset_n`=0 at a clock edge):
- State becomes IDLE.
- `selection`, `counter_register`, `mask_q` and `missed` become 0; `pending` is cleared.
- `SL_out`, `rst` and `busy` are all 0.
- Reset mid-scan has the same effect: no `rst` pulse is emitted.

## Timing
- Latency: `ovf` sampled at edge T → SCAN from T+1, with `SL_out`=1 at T+1.
- Full scan with k enabled channels: k·`SLOT_LEN` SCAN cycles, then 1 CLEAR cycle. Default all-enabled: 192 + 1 = 193 cycles.
- Slot boundary: the last cycle of a slot has `counter_register`=`SLOT_LEN-1`. The next cycle shows the new `selection` with `SL_out`=1.
- Back-to-back frames: with a trigger pending, CLEAR at cycle C is followed by SCAN at C+1 with no IDLE gap.
- Abort sampled at edge T → CLEAR at T+1, IDLE at T+2.
- `missed` updates one cycle after the offending `ovf` sample.

## Test plan
- Default parameters, `ch_en`=0xFFFF, single `ovf` pulse:
  - `selection` runs 0..15, each held 12 cycles.
  - 16 `SL_out` pulses, 12 cycles apart.
  - `rst` is high exactly at cycle 193 after the trigger; `busy` drops at 194.
- `ch_en`=0x8005: `selection` sequence 0, 2, 15, each 12 cycles, then `rst`. Total 37 cycles.
- `ovf` asserted twice during a scan, then a third time:
  - A second scan starts immediately after `rst`, with no IDLE cycle.
  - `missed`=1 after the third trigger.
  - 300 extra triggers saturate `missed` at 255.
- `abort` at `selection`=5, `counter_register`=7 → `rst` the next cycle, then IDLE. A pending trigger is discarded.
- `ch_en`=0 with `ovf` → one `rst` pulse, no `SL_out`, back to IDLE after 2 cycles.
- `reset_n` low mid-scan (N_CH=4, SLOT_LEN=3 instance) → next cycle all outputs 0 and state IDLE. A subsequent `ovf` restarts from channel 0.

Source files
------------

// File: rtl/scan_sequencer.sv
// ---------------------------------------------------------------------------
// scan_sequencer
//   Channel-scan controller for the spectrogram extractor. A frame trigger
//   (ovf) starts a scan that steps the channel select through every channel
//   enabled in the mask captured at scan start. Each channel is held for
//   SLOT_LEN clocks, with a load strobe on the first cycle of each slot. The
//   scan ends with a one-cycle clear pulse. One trigger that arrives while
//   busy is queued. Further triggers are counted as missed, and the count
//   saturates at 255. An abort ends the current scan early.
//
// Ports
//   clk              in   1      single clock, rising edge
//   reset_n          in   1      synchronous active-low reset
//   ovf              in   1      frame trigger, level-sampled every cycle
//   ch_en            in   N_CH   channel-enable mask, captured at scan start
//   abort            in   1      terminate the running scan
//   selection        out  SEL_W  active channel index (0 outside a scan)
//   SL_out           out  1      load strobe on cycle 0 of every slot
//   rst              out  1      end-of-scan clear pulse
//   counter_register out  CNT_W  position within the current slot
//   busy             out  1      high while scanning or clearing
//   missed           out  8      dropped-trigger count, saturating
// ---------------------------------------------------------------------------
module scan_sequencer #(
  parameter int N_CH     = 16,
  parameter int SLOT_LEN = 12,
  parameter int SEL_W    = $clog2(N_CH),
  parameter int CNT_W    = $clog2(SLOT_LEN)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ovf,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             abort,
  output logic [SEL_W-1:0] selection,
  output logic             SL_out,
  output logic             rst,
  output logic [CNT_W-1:0] counter_register,
  output logic             busy,
  output logic [7:0]       missed
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_CLEAR} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_LEN - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]  mask_q, mask_d;
  logic             pend_q, pend_d;
  logic [7:0]       missed_q, missed_d;
  logic             start_d;

  // True when any channel at or above 'start' is enabled in m.
  function automatic logic has_from(input logic [N_CH-1:0] m, input int start);
    logic found;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (i >= start && m[i]) found = 1'b1;
    end
    return found;
  endfunction

  // Lowest enabled channel at or above 'start'. Returns 0 if there is none.
  function automatic logic [SEL_W-1:0] idx_from(input logic [N_CH-1:0] m, input int start);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i >= start && m[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      mask_q   <= '0;
      pend_q   <= 1'b0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      missed_q <= missed_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    pend_d   = pend_q;
    missed_d = missed_q;
    start_d  = 1'b0;

    // Trigger queue: a busy-time trigger fills the single slot or counts as
    // missed. The CLEAR cycle counts as busy and judges against the slot
    // contents before this cycle consumes them.
    if (state_q != S_IDLE && ovf) begin
      if (pend_q) missed_d = sat_inc(missed_q);
      else        pend_d   = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        // A trigger queued on the final CLEAR cycle lands here and starts
        // the next scan without needing a new ovf.
        if (ovf || pend_q) begin
          pend_d  = 1'b0;
          start_d = 1'b1;
        end
      end
      S_SCAN: begin
        if (abort) begin
          state_d = S_CLEAR;
          sel_d   = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (has_from(mask_q, int'(sel_q) + 1)) begin
            sel_d = idx_from(mask_q, int'(sel_q) + 1);
          end else begin
            state_d = S_CLEAR;
            sel_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          start_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Scan start: capture the mask. An empty mask goes straight to CLEAR.
    if (start_d) begin
      mask_d = ch_en;
      cnt_d  = '0;
      if (|ch_en) begin
        state_d = S_SCAN;
        sel_d   = idx_from(ch_en, 0);
      end else begin
        state_d = S_CLEAR;
        sel_d   = '0;
      end
    end
  end

  // Output decode (Moore, from registers only)
  always_comb begin
    selection        = (state_q == S_SCAN) ? sel_q : '0;
    SL_out           = (state_q == S_SCAN) && (cnt_q == '0);
    rst              = (state_q == S_CLEAR);
    busy             = (state_q != S_IDLE);
    counter_register = cnt_q;
    missed           = missed_q;
  end

endmodule

// File: tb/tb_scan_sequencer.sv
module tb_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset_n, ovf, abort;
  logic [15:0] ch_en;
  logic [3:0]  selection;
  logic        SL_out, rst, busy;
  logic [3:0]  counter_register;
  logic [7:0]  missed;

  logic        reset_n_s, ovf_s, abort_s;
  logic [3:0]  ch_en_s;
  logic [1:0]  selection_s;
  logic        SL_out_s, rst_s, busy_s;
  logic [1:0]  counter_register_s;
  logic [7:0]  missed_s;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  scan_sequencer dut (
    .clk(clk), .reset_n(reset_n), .ovf(ovf), .ch_en(ch_en), .abort(abort),
    .selection(selection), .SL_out(SL_out), .rst(rst),
    .counter_register(counter_register), .busy(busy), .missed(missed)
  );

  scan_sequencer #(.N_CH(4), .SLOT_LEN(3)) dut_s (
    .clk(clk), .reset_n(reset_n_s), .ovf(ovf_s), .ch_en(ch_en_s), .abort(abort_s),
    .selection(selection_s), .SL_out(SL_out_s), .rst(rst_s),
    .counter_register(counter_register_s), .busy(busy_s), .missed(missed_s)
  );

  // Reference model: a scan is a list of future cycles. Each entry is one
  // clock showing a channel slot position or the clear cycle. An empty list
  // means idle.
  typedef struct { int sel; int cnt; bit clr; } slot_t;
  slot_t m_plan[$];
  bit    m_pend   = 1'b0;
  int    m_missed = 0;

  task automatic build_plan(input logic [15:0] m);
    for (int ch = 0; ch < 16; ch++)
      if (m[ch])
        for (int c = 0; c < 12; c++) m_plan.push_back('{ch, c, 1'b0});
    m_plan.push_back('{0, 0, 1'b1});
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      m_plan.delete();
      m_pend   = 1'b0;
      m_missed = 0;
    end else if (m_plan.size() == 0) begin
      if (ovf || m_pend) begin
        m_pend = 1'b0;
        build_plan(ch_en);
      end
    end else begin
      bit was_clr;
      bit old_pend;
      was_clr  = m_plan[0].clr;
      old_pend = m_pend;
      if (ovf && old_pend && m_missed < 255) m_missed++;
      if (!was_clr && abort) begin
        m_plan.delete();
        m_plan.push_back('{0, 0, 1'b1});
        m_pend = 1'b0;
      end else begin
        if (ovf && !old_pend) m_pend = 1'b1;
        void'(m_plan.pop_front());
        if (was_clr && old_pend) begin
          m_pend = 1'b0;
          build_plan(ch_en);
        end
      end
    end
  end

  // Every cycle, compare the default instance against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      int e_sel, e_cnt;
      bit e_sl, e_rst, e_busy;
      if (m_plan.size() == 0) begin
        e_sel = 0; e_cnt = 0; e_sl = 0; e_rst = 0; e_busy = 0;
      end else begin
        e_busy = 1;
        e_rst  = m_plan[0].clr;
        e_sel  = m_plan[0].clr ? 0 : m_plan[0].sel;
        e_cnt  = m_plan[0].clr ? 0 : m_plan[0].cnt;
        e_sl   = !m_plan[0].clr && (m_plan[0].cnt == 0);
      end
      n_cmp++;
      if (int'(selection) != e_sel || int'(counter_register) != e_cnt || SL_out != e_sl ||
          rst != e_rst || busy != e_busy || int'(missed) != m_missed) begin
        n_fail++;
        $display("FAIL model t=%0t got sel=%0d cnt=%0d sl=%0b rst=%0b busy=%0b missed=%0d want sel=%0d cnt=%0d sl=%0b rst=%0b busy=%0b missed=%0d",
                 $time, selection, counter_register, SL_out, rst, busy, missed,
                 e_sel, e_cnt, e_sl, e_rst, e_busy, m_missed);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  typedef struct { logic [15:0] ch_en; int exp_busy; int exp_sl; int exp_last_sel; } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{16'hFFFF, 193, 16, 15};
    tbl[1] = '{16'h8005,  37,  3, 15};
    tbl[2] = '{16'h0000,   1,  0,  0};
    tbl[3] = '{16'h0001,  13,  1,  0};
    tbl[4] = '{16'h8000,  13,  1, 15};
    tbl[5] = '{16'h0110,  25,  2,  8};

    reset_n = 0; ovf = 0; abort = 0; ch_en = '0;
    reset_n_s = 0; ovf_s = 0; abort_s = 0; ch_en_s = 4'hF;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sel", selection, 0);
    check("rst_sl", SL_out, 0);
    check("rst_clr", rst, 0);
    check("rst_missed", missed, 0);
    check("rst_s_busy", busy_s, 0);
    reset_n = 1; reset_n_s = 1;
    chk_en = 1;
    @(negedge clk);

    // Small instance: reset in the middle of a scan
    ovf_s = 1; @(negedge clk); ovf_s = 0;
    check("s_start_sl", SL_out_s, 1);
    repeat (4) @(negedge clk);
    check("s_mid_sel", selection_s, 1);
    check("s_mid_cnt", counter_register_s, 1);
    reset_n_s = 0; @(negedge clk); reset_n_s = 1;
    check("s_rst_out", {selection_s, counter_register_s, SL_out_s, rst_s, busy_s, missed_s}, 0);
    @(negedge clk);
    check("s_rst_no_pulse", {rst_s, busy_s}, 0);
    ovf_s = 1; @(negedge clk); ovf_s = 0;
    check("s_restart_sel", selection_s, 0);
    check("s_restart_sl", SL_out_s, 1);
    check("s_restart_busy", busy_s, 1);

    // Table: single-trigger scans with different masks
    for (int v = 0; v < 6; v++) begin
      int cyc, sl_n, rst_n, rst_at, last_sel;
      ch_en = tbl[v].ch_en; ovf = 1;
      @(negedge clk); ovf = 0;
      cyc = 0; sl_n = 0; rst_n = 0; rst_at = -1; last_sel = 0;
      while (busy && cyc < 1000) begin
        cyc++;
        if (SL_out) begin sl_n++; last_sel = selection; end
        if (rst) begin rst_n++; rst_at = cyc; end
        @(negedge clk);
      end
      check($sformatf("tbl%0d_busy_len", v), cyc, tbl[v].exp_busy);
      check($sformatf("tbl%0d_sl_count", v), sl_n, tbl[v].exp_sl);
      check($sformatf("tbl%0d_rst_count", v), rst_n, 1);
      check($sformatf("tbl%0d_rst_at", v), rst_at, tbl[v].exp_busy);
      check($sformatf("tbl%0d_last_sel", v), last_sel, tbl[v].exp_last_sel);
      repeat (2) @(negedge clk);
    end

    // Abort at channel 5, count 7 with a trigger pending
    begin
      int g;
      ch_en = 16'hFFFF; ovf = 1; @(negedge clk); ovf = 0;
      repeat (3) @(negedge clk);
      ovf = 1; @(negedge clk); ovf = 0;
      g = 0;
      while (!(selection == 4'd5 && counter_register == 4'd7) && g < 300) begin
        @(negedge clk); g++;
      end
      check("abort_reach", int'(g < 300), 1);
      abort = 1; @(negedge clk); abort = 0;
      check("abort_rst", rst, 1);
      check("abort_sel", selection, 0);
      @(negedge clk);
      check("abort_idle", busy, 0);
      repeat (3) @(negedge clk);
      check("abort_pend_dropped", busy, 0);
    end

    // Back-to-back: trigger, then two more during the scan
    begin
      int cyc, rst_n;
      ch_en = 16'hFFFF; ovf = 1; @(negedge clk); ovf = 0;
      cyc = 0; rst_n = 0;
      while (busy && cyc < 1000) begin
        cyc++;
        if (rst) rst_n++;
        ovf = (cyc == 5 || cyc == 10);
        @(negedge clk);
      end
      ovf = 0;
      check("b2b_busy_len", cyc, 386);
      check("b2b_rst_count", rst_n, 2);
      check("b2b_missed", missed, 1);
    end

    // Saturation of the missed counter
    ovf = 1;
    repeat (300) @(negedge clk);
    ovf = 0;
    @(negedge clk);
    check("sat_missed", missed, 255);
    reset_n = 0; @(negedge clk); reset_n = 1;
    check("sat_reset_missed", missed, 0);
    check("sat_reset_busy", busy, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      ovf   = ($urandom % 20) == 0;
      abort = ($urandom % 150) == 0;
      if (($urandom % 40) == 0) begin
        case ($urandom % 3)
          0: ch_en = '0;
          1: ch_en = 16'($urandom & $urandom & $urandom);
          default: ch_en = 16'($urandom);
        endcase
      end
      reset_n = ($urandom % 1500) != 0;
      @(negedge clk);
    end
    ovf = 0; abort = 0; reset_n = 1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
